snow64_lar_mem_access_ctrl: RTL and testbench
=============================================

# snow64_lar_mem_access_ctrl

Sits between the LAR file's memory-side ports and the memory bus guard. Accepts the LAR file's independent line-read and line-write requests and serializes them onto one line-wide memory port, writes before reads. Returns completion pulses, read data and per-channel busy flags to the LAR file. Holds at most one pending read and one pending write.

## Interface
- `DATA_WIDTH`, 256: width of one LAR data line (32 bytes).
- `BASE_ADDR_WIDTH`, 59: line base address width (64-bit address minus 5 offset bits).
- `clk  in  1`: clock.
- `rst  in  1`: synchronous, active-high reset.
- `lar_rd_req  in  1`: LAR file requests a line read.
- `lar_rd_base_addr  in  BASE_ADDR_WIDTH`: line to read.
- `lar_wr_req  in  1`: LAR file requests a line write-back.
- `lar_wr_base_addr  in  BASE_ADDR_WIDTH`: line to write.
- `lar_wr_data  in  DATA_WIDTH`: line data to write.
- `lar_rd_valid  out  1`: one-cycle pulse; `lar_rd_data` is valid.
- `lar_rd_data  out  DATA_WIDTH`: returned line.
- `lar_rd_busy  out  1`: read channel cannot accept a request.
- `lar_wr_valid  out  1`: one-cycle pulse; the write has completed.
- `lar_wr_busy  out  1`: write channel cannot accept a request.
- `mem_req  out  1`: memory transaction request.
- `mem_we  out  1`: 1 = write, 0 = read.
- `mem_base_addr  out  BASE_ADDR_WIDTH`: transaction line address.
- `mem_wdata  out  DATA_WIDTH`: write data.
- `mem_ack  in  1`: bus guard completion pulse.
- `mem_rdata  in  DATA_WIDTH`: read data, valid when `mem_ack` is high and `mem_we` is 0.

## Operation
- Acceptance:
  - A read is captured when `lar_rd_req && !lar_rd_busy`. Store its address and set the read-pending bit.
  - A write is captured when `lar_wr_req && !lar_wr_busy`. Store its address and data and set the write-pending bit.
  - A request seen while its channel is busy is ignored.
- Busy flags:
  - `lar_rd_busy` = read pending, or read in flight, or the cycle of `lar_rd_valid`.
  - `lar_wr_busy` follows the same rule for the write channel.
- State machine, states `StIdle`, `StWr`, `StRd`:
  - `StIdle`:
    - If a write is pending, go to `StWr`.
    - Otherwise, if a read is pending, go to `StRd`.
    - A write always wins, so a dirty eviction precedes the refill that replaces it.
  - `StWr`:
    - Drive `mem_req=1`, `mem_we=1`, and the stored address and data.
    - On `mem_ack`: pulse `lar_wr_valid` next cycle and clear write-pending.
    - Then go to `StRd` if a read is pending, else `StIdle`.
  - `StRd`:
    - Drive `mem_req=1`, `mem_we=0`, and the stored address.
    - On `mem_ack`: register `mem_rdata` into `lar_rd_data`, pulse `lar_rd_valid` next cycle, clear read-pending, and go to `StIdle`.
- Memory outputs are registered and held stable from the first `mem_req` cycle until the `mem_ack` cycle inclusive. `mem_req` drops in the cycle after `mem_ack`.
- `mem_ack` is ignored in `StIdle`.
- `lar_rd_data` holds its last value between reads.

## Timing
- Reset:
  - Machine goes to `StIdle`, both pending bits clear.
  - All outputs are 0: `mem_req`, `mem_we`, `mem_base_addr`, `mem_wdata`, `lar_rd_valid`, `lar_rd_data`, `lar_wr_valid`, `lar_rd_busy`, `lar_wr_busy`.
  - Reset during a transaction abandons it silently; no valid pulse is produced.
- Latency:
  - Request accepted in cycle T: busy=1 at T+1, `mem_req`=1 at T+2 (idle machine).
  - With `mem_ack` at cycle A: valid=1 at A+1, busy=0 at A+2.
  - A new request may be accepted in cycle A+2.
- Read and write accepted in the same cycle T:
  - Write `mem_req` starts at T+2.
  - The read transaction starts the cycle after the write `mem_ack`.
- A request arriving while the other channel is in flight is queued and issued after the current transaction.
- `mem_ack` may arrive as early as the first `mem_req` cycle. There is no upper bound on the wait.

## Configuration
- `SNOW64_LAR_MEM_ACCESS_WR_FORWARD_EN` defined:
  - On entering `StRd`, if a read's address equals the address of the write that just completed, skip the memory read.
  - Return the stored write data instead, with `lar_rd_valid` one cycle after the write `lar_wr_valid`.
  - No `mem_req` is issued for that read.
- Macro undefined: every read goes to memory.

## Test plan
- Single read of address 0x10: `mem_ack` with `mem_rdata=0xAA..AA` three cycles after `mem_req`.
  - Expect exactly one read transaction at 0x10.
  - `lar_rd_valid` one cycle after the ack with data 0xAA..AA; `lar_rd_busy` low two cycles after the ack.
- Read of 0x20 and write of 0x30 (data 0x55..55) in the same cycle.
  - Expect the write transaction to 0x30 first, then the read of 0x20.
  - `lar_wr_valid` precedes `lar_rd_valid`.
- `lar_rd_req` held high while `lar_rd_busy=1`: expect exactly one transaction.
- `mem_ack` delayed 20 cycles: `mem_req`, `mem_we`, `mem_base_addr` and `mem_wdata` stay constant throughout; ack on the first `mem_req` cycle also completes correctly.
- `rst` asserted mid-`StWr`: expect all outputs 0 next cycle and no `lar_wr_valid`; a following read at 0x40 completes normally.
- Write of 0x50 (data 0x11..11), then a read of 0x50 queued behind it:
  - With the macro defined: `lar_rd_data=0x11..11` and no read `mem_req`.
  - Macro undefined: the read is issued to memory.

Source files
------------

// File: rtl/snow64_lar_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : snow64_lar_mem_access_ctrl
// Brief    : Serializes LAR line reads/writes onto one memory port, writes
//            first. Optional macro SNOW64_LAR_MEM_ACCESS_WR_FORWARD_EN.
// Revision : 1.0
// ============================================================================
module snow64_lar_mem_access_ctrl #(
    parameter int DATA_WIDTH      = 256,
    parameter int BASE_ADDR_WIDTH = 59
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       lar_rd_req,
    input  logic [BASE_ADDR_WIDTH-1:0] lar_rd_base_addr,
    input  logic                       lar_wr_req,
    input  logic [BASE_ADDR_WIDTH-1:0] lar_wr_base_addr,
    input  logic [DATA_WIDTH-1:0]      lar_wr_data,
    output logic                       lar_rd_valid,
    output logic [DATA_WIDTH-1:0]      lar_rd_data,
    output logic                       lar_rd_busy,
    output logic                       lar_wr_valid,
    output logic                       lar_wr_busy,
    output logic                       mem_req,
    output logic                       mem_we,
    output logic [BASE_ADDR_WIDTH-1:0] mem_base_addr,
    output logic [DATA_WIDTH-1:0]      mem_wdata,
    input  logic                       mem_ack,
    input  logic [DATA_WIDTH-1:0]      mem_rdata
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWr   = 2'd1,
        StRd   = 2'd2
    } state_e;

`ifdef SNOW64_LAR_MEM_ACCESS_WR_FORWARD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    state_e                     state_q;
    logic                       rd_pend_q;
    logic                       wr_pend_q;
    logic [BASE_ADDR_WIDTH-1:0] rd_addr_q;
    logic [BASE_ADDR_WIDTH-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0]      wr_data_q;
    logic                       fwd_q;
    logic                       rd_valid_q;
    logic                       wr_valid_q;
    logic [DATA_WIDTH-1:0]      rd_data_q;
    logic                       mem_req_q;
    logic                       mem_we_q;
    logic [BASE_ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0]      mem_wdata_q;

    logic w_rd_accept;
    logic w_wr_accept;
    logic w_fwd_hit;

    // Pending bit covers queued and in-flight; the valid pulse extends busy by one cycle
    assign lar_rd_busy = rd_pend_q | rd_valid_q;
    assign lar_wr_busy = wr_pend_q | wr_valid_q;
    assign w_rd_accept = lar_rd_req & ~lar_rd_busy;
    assign w_wr_accept = lar_wr_req & ~lar_wr_busy;
    assign w_fwd_hit   = FWD_EN & (rd_addr_q == wr_addr_q);

    assign lar_rd_valid  = rd_valid_q;
    assign lar_rd_data   = rd_data_q;
    assign lar_wr_valid  = wr_valid_q;
    assign mem_req       = mem_req_q;
    assign mem_we        = mem_we_q;
    assign mem_base_addr = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            rd_pend_q   <= 1'b0;
            wr_pend_q   <= 1'b0;
            rd_addr_q   <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            fwd_q       <= 1'b0;
            rd_valid_q  <= 1'b0;
            wr_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            rd_valid_q <= 1'b0;
            wr_valid_q <= 1'b0;

            case (state_q)
                StIdle: begin
                    if (wr_pend_q) begin
                        state_q     <= StWr;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= wr_addr_q;
                        mem_wdata_q <= wr_data_q;
                    end else if (rd_pend_q) begin
                        state_q    <= StRd;
                        fwd_q      <= 1'b0;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= rd_addr_q;
                    end
                end
                StWr: begin
                    if (mem_ack) begin
                        wr_valid_q <= 1'b1;
                        wr_pend_q  <= 1'b0;
                        mem_we_q   <= 1'b0;
                        if (rd_pend_q) begin
                            // A read hitting the line just written is served from wr_data_q
                            state_q    <= StRd;
                            fwd_q      <= w_fwd_hit;
                            mem_req_q  <= ~w_fwd_hit;
                            mem_addr_q <= rd_addr_q;
                        end else begin
                            state_q   <= StIdle;
                            mem_req_q <= 1'b0;
                        end
                    end
                end
                StRd: begin
                    if (fwd_q) begin
                        state_q    <= StIdle;
                        fwd_q      <= 1'b0;
                        rd_data_q  <= wr_data_q;
                        rd_valid_q <= 1'b1;
                        rd_pend_q  <= 1'b0;
                    end else if (mem_ack) begin
                        state_q    <= StIdle;
                        rd_data_q  <= mem_rdata;
                        rd_valid_q <= 1'b1;
                        rd_pend_q  <= 1'b0;
                        mem_req_q  <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase

            // Busy blocks acceptance while pending, so set never collides with clear
            if (w_rd_accept) begin
                rd_pend_q <= 1'b1;
                rd_addr_q <= lar_rd_base_addr;
            end
            if (w_wr_accept) begin
                wr_pend_q <= 1'b1;
                wr_addr_q <= lar_wr_base_addr;
                wr_data_q <= lar_wr_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_snow64_lar_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_snow64_lar_mem_access_ctrl
// Brief    : Directed self-checking bench for snow64_lar_mem_access_ctrl.
// Revision : 1.0
// ============================================================================
module tb_snow64_lar_mem_access_ctrl;

    localparam int DW = 256;
    localparam int AW = 59;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          lar_rd_req = 1'b0;
    logic [AW-1:0] lar_rd_base_addr = '0;
    logic          lar_wr_req = 1'b0;
    logic [AW-1:0] lar_wr_base_addr = '0;
    logic [DW-1:0] lar_wr_data = '0;
    logic          lar_rd_valid;
    logic [DW-1:0] lar_rd_data;
    logic          lar_rd_busy;
    logic          lar_wr_valid;
    logic          lar_wr_busy;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_base_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    int n_vec = 0;
    int n_err = 0;
    int n_txn = 0;

    snow64_lar_mem_access_ctrl #(.DATA_WIDTH(DW), .BASE_ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .lar_rd_req(lar_rd_req), .lar_rd_base_addr(lar_rd_base_addr),
        .lar_wr_req(lar_wr_req), .lar_wr_base_addr(lar_wr_base_addr),
        .lar_wr_data(lar_wr_data),
        .lar_rd_valid(lar_rd_valid), .lar_rd_data(lar_rd_data),
        .lar_rd_busy(lar_rd_busy),
        .lar_wr_valid(lar_wr_valid), .lar_wr_busy(lar_wr_busy),
        .mem_req(mem_req), .mem_we(mem_we), .mem_base_addr(mem_base_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Completed memory transactions
    always @(posedge clk) begin
        if (!rst && mem_req && mem_ack) n_txn <= n_txn + 1;
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] fill(input logic [7:0] b);
        return {32{b}};
    endfunction

    task automatic wait_req();
        for (int i = 0; i < 50 && !mem_req; i++) tick();
        if (!mem_req) check("req_timeout", 0, 1);
    endtask

    // Pulse mem_ack for one cycle; returns in the cycle after the ack
    task automatic ack(input logic [DW-1:0] d);
        mem_ack   = 1'b1;
        mem_rdata = d;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = '0;
    endtask

    logic          snap_we;
    logic [AW-1:0] snap_addr;
    logic [DW-1:0] snap_wdata;
    bit            stable;
    bit            saw_wv;
    int            t0;

    initial begin
        // Reset state
        tick(); tick();
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_base_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_rd_valid", lar_rd_valid, 0);
        check("rst_rd_data", lar_rd_data, 0);
        check("rst_wr_valid", lar_wr_valid, 0);
        check("rst_busy", {lar_rd_busy, lar_wr_busy}, 0);
        rst = 1'b0;
        tick();

        // Single read of 0x10, ack three cycles after mem_req
        t0 = n_txn;
        lar_rd_req = 1'b1; lar_rd_base_addr = 'h10;
        tick();
        lar_rd_req = 1'b0;
        check("t1_busy_T1", lar_rd_busy, 1);
        check("t1_req_T1", mem_req, 0);
        tick();
        check("t1_req_T2", {mem_req, mem_we}, 2'b10);
        check("t1_addr", mem_base_addr, 'h10);
        tick(); tick(); tick();
        ack(fill(8'hAA));
        check("t1_valid", lar_rd_valid, 1);
        check("t1_data", lar_rd_data, fill(8'hAA));
        check("t1_busy_A1", lar_rd_busy, 1);
        check("t1_req_drop", mem_req, 0);
        tick();
        check("t1_valid_A2", lar_rd_valid, 0);
        check("t1_busy_A2", lar_rd_busy, 0);
        check("t1_data_hold", lar_rd_data, fill(8'hAA));
        check("t1_ntxn", n_txn - t0, 1);

        // Read 0x20 and write 0x30 accepted together; ack on the first req cycle
        lar_rd_req = 1'b1; lar_rd_base_addr = 'h20;
        lar_wr_req = 1'b1; lar_wr_base_addr = 'h30; lar_wr_data = fill(8'h55);
        tick();
        lar_rd_req = 1'b0; lar_wr_req = 1'b0;
        check("t2_busy", {lar_rd_busy, lar_wr_busy}, 2'b11);
        tick();
        check("t2_wr_req", {mem_req, mem_we}, 2'b11);
        check("t2_wr_addr", mem_base_addr, 'h30);
        check("t2_wr_data", mem_wdata, fill(8'h55));
        ack('0);
        check("t2_wr_valid", {lar_wr_valid, lar_rd_valid}, 2'b10);
        check("t2_rd_req", {mem_req, mem_we}, 2'b10);
        check("t2_rd_addr", mem_base_addr, 'h20);
        ack(fill(8'h33));
        check("t2_rd_valid", {lar_wr_valid, lar_rd_valid}, 2'b01);
        check("t2_rd_data", lar_rd_data, fill(8'h33));
        check("t2_req_drop", mem_req, 0);
        tick();

        // Read request held high while busy
        t0 = n_txn;
        lar_rd_req = 1'b1; lar_rd_base_addr = 'h60;
        wait_req();
        tick(); tick();
        ack(fill(8'h66));
        check("t3_valid", lar_rd_valid, 1);
        lar_rd_req = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("t3_ntxn", n_txn - t0, 1);
        check("t3_idle", {mem_req, lar_rd_busy}, 0);

        // Write with ack delayed 20 cycles: memory outputs stay constant
        lar_wr_req = 1'b1; lar_wr_base_addr = 'h70; lar_wr_data = {8{32'hDEADBEEF}};
        tick();
        lar_wr_req = 1'b0;
        wait_req();
        snap_we = mem_we; snap_addr = mem_base_addr; snap_wdata = mem_wdata;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!mem_req || mem_we !== snap_we || mem_base_addr !== snap_addr ||
                mem_wdata !== snap_wdata) stable = 1'b0;
        end
        check("t4_stable", stable, 1);
        check("t4_fields", {snap_we, snap_addr}, {1'b1, 59'h70});
        check("t4_wdata", snap_wdata, {8{32'hDEADBEEF}});
        ack('0);
        check("t4_wr_valid", lar_wr_valid, 1);
        tick();

        // Reset in the middle of a write transaction
        lar_wr_req = 1'b1; lar_wr_base_addr = 'h80; lar_wr_data = fill(8'h77);
        tick();
        lar_wr_req = 1'b0;
        wait_req();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_mem_zero", {mem_req, mem_we, mem_base_addr}, 0);
        check("t5_wdata_zero", mem_wdata, 0);
        check("t5_lar_zero", {lar_wr_valid, lar_wr_busy, lar_rd_valid, lar_rd_busy}, 0);
        check("t5_rd_data_zero", lar_rd_data, 0);
        saw_wv = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (lar_wr_valid || mem_req) saw_wv = 1'b1;
        end
        check("t5_no_wv", saw_wv, 0);
        lar_rd_req = 1'b1; lar_rd_base_addr = 'h40;
        tick();
        lar_rd_req = 1'b0;
        wait_req();
        check("t5_rd_addr", {mem_we, mem_base_addr}, {1'b0, 59'h40});
        ack(fill(8'h44));
        check("t5_rd_data", {lar_rd_valid, lar_rd_data}, {1'b1, fill(8'h44)});
        tick();

        // Write 0x50 then a read of 0x50 queued behind it
        t0 = n_txn;
        lar_wr_req = 1'b1; lar_wr_base_addr = 'h50; lar_wr_data = fill(8'h11);
        tick();
        lar_wr_req = 1'b0;
        lar_rd_req = 1'b1; lar_rd_base_addr = 'h50;
        tick();
        lar_rd_req = 1'b0;
        check("t6_wr_req", {mem_req, mem_we, mem_base_addr}, {2'b11, 59'h50});
        tick(); tick();
        ack('0);
        check("t6_wr_valid", lar_wr_valid, 1);
`ifdef SNOW64_LAR_MEM_ACCESS_WR_FORWARD_EN
        check("t6_no_rd_req", mem_req, 0);
        tick();
        check("t6_fwd_valid", lar_rd_valid, 1);
        check("t6_fwd_data", lar_rd_data, fill(8'h11));
        tick();
        check("t6_ntxn", n_txn - t0, 1);
`else
        check("t6_rd_req", {mem_req, mem_we, mem_base_addr}, {2'b10, 59'h50});
        ack(fill(8'h99));
        check("t6_rd_valid", lar_rd_valid, 1);
        check("t6_rd_data", lar_rd_data, fill(8'h99));
        tick();
        check("t6_ntxn", n_txn - t0, 2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
